mips_cpu_avalon_ram_ws: RTL and testbench

//  Parametrised Avalon-MM slave memory model for the MIPS CPU testbench; successor of the fixed 4K-word bench RAM.

---
 rtl/mips_cpu_avalon_ram_pkg.sv | 29 ++
 rtl/mips_cpu_wait_lfsr.sv | 28 ++
 rtl/mips_cpu_avalon_ram_ws.sv | 190 +++++++++++++++++++
 tb/tb_mips_cpu_avalon_ram_ws.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_avalon_ram_pkg.sv
// Shared types and helpers for the Avalon-MM wait-state RAM model.
//   wait_mode_t : how the per-request wait count is chosen
//   ram_state_t : slave handshake state
//   LFSR_TAPS   : Galois feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
//   be_mask()   : expands a 4-bit byteenable into a 32-bit lane mask
package mips_cpu_avalon_ram_pkg;

    typedef enum logic [1:0] {
        WAIT_NONE  = 2'd0,
        WAIT_FIXED = 2'd1,
        WAIT_LFSR  = 2'd2
    } wait_mode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } ram_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/mips_cpu_wait_lfsr.sv
// 16-bit Galois LFSR used to draw pseudo-random wait counts.
//   clk, rst_n : clock, asynchronous active-low reset (loads i_seed)
//   i_seed     : reset value, must be non-zero
//   i_adv      : advance one step on this clock edge
//   o_state    : current LFSR state
module mips_cpu_wait_lfsr
    import mips_cpu_avalon_ram_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_seed,
    input  logic        i_adv,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= i_seed;
        end else if (i_adv) begin
            r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/mips_cpu_avalon_ram_ws.sv
// Avalon-MM slave memory model with configurable wait states for the MIPS CPU bench.
//   clk, rst_n           : clock, asynchronous active-low reset
//   address, byteenable  : byte address (bits [1:0] ignored), lane enables
//   read, write          : request strobes, held by the master while waitrequest=1
//   writedata            : write data
//   waitrequest          : stall; transfer accepted when (read|write) && !waitrequest
//   readdata             : registered read data (masked by byteenable)
//   readdatavalid        : one-cycle pulse after an accepted read
//   range_error          : sticky, accepted access outside the mapped window
//   proto_error          : sticky, read+write together or request dropped/changed while stalled
//   rd_count, wr_count   : saturating counts of accepted reads / writes
// The memory array has no reset; its contents survive rst_n.
module mips_cpu_avalon_ram_ws
    import mips_cpu_avalon_ram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_MODE   = 2,
    parameter int          FIXED_WAIT  = 1,
    parameter int          MAX_WAIT    = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [3:0]  byteenable,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        range_error,
    output logic        proto_error,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);
    localparam wait_mode_t  MODE  = wait_mode_t'(2'(WAIT_MODE));

    logic [31:0]      r_mem [DEPTH_WORDS];
    ram_state_t       r_state, w_next;
    logic [3:0]       r_cnt;
    logic [29:0]      r_hold_addr;
    logic             r_hold_rd, r_hold_wr;
    logic [3:0]       r_hold_be;
    logic [31:0]      r_readdata, r_rd_count, r_wr_count;
    logic             r_rvalid, r_range_err, r_proto_err;

    logic [15:0]      w_lfsr;
    logic             w_lfsr_unused;
    logic [3:0]       w_draw;
    logic [31:0]      w_off;
    logic [IDX_W-1:0] w_idx;
    logic             w_in_range, w_req, w_match;
    logic             w_wait, w_accept, w_perr, w_load, w_dec, w_adv;

    mips_cpu_wait_lfsr u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_seed  (LFSR_SEED),
        .i_adv   (w_adv),
        .o_state (w_lfsr)
    );

    // Only the low nibble feeds the wait draw.
    assign w_lfsr_unused = ^w_lfsr[15:4];

    // Offset from the base wraps modulo the array size; the range flag catches strays.
    assign w_off      = address - BASE_ADDR;
    assign w_idx      = w_off[IDX_W+1:2];
    assign w_in_range = (w_off < SPAN);

    // Requests are ignored while reset is held so waitrequest drops immediately.
    assign w_req   = rst_n && (read || write);
    assign w_match = w_req && (read == r_hold_rd) && (write == r_hold_wr) &&
                     (address[31:2] == r_hold_addr) && (byteenable == r_hold_be);

    always_comb begin
        w_draw = 4'd0;
        case (MODE)
            WAIT_FIXED: w_draw = 4'(FIXED_WAIT);
            WAIT_LFSR:  w_draw = 4'({1'b0, w_lfsr[3:0]} % 5'(MAX_WAIT + 1));
            default:    w_draw = 4'd0;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_wait   = 1'b0;
        w_accept = 1'b0;
        w_perr   = 1'b0;
        w_load   = 1'b0;
        w_dec    = 1'b0;
        w_adv    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_adv = 1'b1;
                    if (w_draw == 4'd0) begin
                        w_accept = 1'b1;
                    end else begin
                        w_wait = 1'b1;
                        w_load = 1'b1;
                        w_next = STALL;
                    end
                end
            end
            STALL: begin
                if (!w_match) begin
                    // A changed request stays stalled and is re-drawn as new from IDLE.
                    w_perr = 1'b1;
                    w_wait = w_req;
                    w_next = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_accept = 1'b1;
                    w_next   = IDLE;
                end else begin
                    w_wait = 1'b1;
                    w_dec  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_hold_addr <= 30'd0;
            r_hold_rd   <= 1'b0;
            r_hold_wr   <= 1'b0;
            r_hold_be   <= 4'd0;
            r_readdata  <= 32'd0;
            r_rvalid    <= 1'b0;
            r_range_err <= 1'b0;
            r_proto_err <= 1'b0;
            r_rd_count  <= 32'd0;
            r_wr_count  <= 32'd0;
        end else begin
            r_state  <= w_next;
            r_rvalid <= 1'b0;
            if (w_load) begin
                r_cnt       <= w_draw - 4'd1;
                r_hold_addr <= address[31:2];
                r_hold_rd   <= read;
                r_hold_wr   <= write;
                r_hold_be   <= byteenable;
            end else if (w_dec) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_perr) begin
                r_proto_err <= 1'b1;
            end
            if (w_accept) begin
                if (!w_in_range) begin
                    r_range_err <= 1'b1;
                end
                if (read && write) begin
                    r_proto_err <= 1'b1;
                end else if (read) begin
                    r_readdata <= r_mem[w_idx] & be_mask(byteenable);
                    r_rvalid   <= 1'b1;
                    if (r_rd_count != 32'hFFFF_FFFF) r_rd_count <= r_rd_count + 32'd1;
                end else begin
                    if (r_wr_count != 32'hFFFF_FFFF) r_wr_count <= r_wr_count + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && write && !read) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) r_mem[w_idx][8*i +: 8] <= writedata[8*i +: 8];
            end
        end
    end

    assign waitrequest   = w_wait;
    assign readdata      = r_readdata;
    assign readdatavalid = r_rvalid;
    assign range_error   = r_range_err;
    assign proto_error   = r_proto_err;
    assign rd_count      = r_rd_count;
    assign wr_count      = r_wr_count;

endmodule

// File: tb/tb_mips_cpu_avalon_ram_ws.sv
// Bench for mips_cpu_avalon_ram_ws: three instances (no waits, fixed 3 waits,
// LFSR waits) driven by directed transfers, checked every cycle against a
// request-level model plus literal expectations.
module tb_mips_cpu_avalon_ram_ws;

    localparam logic [31:0] BASE = 32'hBFC00000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [3];
    logic [31:0] address [3];
    logic [3:0]  be      [3];
    logic        rd      [3];
    logic        wr      [3];
    logic [31:0] wd      [3];
    logic        waitreq [3];
    logic [31:0] rdata   [3];
    logic        rvalid  [3];
    logic        rerr    [3];
    logic        perr    [3];
    logic [31:0] rdc     [3];
    logic [31:0] wrc     [3];

    mips_cpu_avalon_ram_ws #(.WAIT_MODE(0)) u_m0 (
        .clk(clk), .rst_n(rst_n[0]), .address(address[0]), .byteenable(be[0]),
        .read(rd[0]), .write(wr[0]), .writedata(wd[0]), .waitrequest(waitreq[0]),
        .readdata(rdata[0]), .readdatavalid(rvalid[0]), .range_error(rerr[0]),
        .proto_error(perr[0]), .rd_count(rdc[0]), .wr_count(wrc[0]));

    mips_cpu_avalon_ram_ws #(.WAIT_MODE(1), .FIXED_WAIT(3)) u_m1 (
        .clk(clk), .rst_n(rst_n[1]), .address(address[1]), .byteenable(be[1]),
        .read(rd[1]), .write(wr[1]), .writedata(wd[1]), .waitrequest(waitreq[1]),
        .readdata(rdata[1]), .readdatavalid(rvalid[1]), .range_error(rerr[1]),
        .proto_error(perr[1]), .rd_count(rdc[1]), .wr_count(wrc[1]));

    mips_cpu_avalon_ram_ws #(.WAIT_MODE(2), .MAX_WAIT(4), .LFSR_SEED(16'hACE1)) u_m2 (
        .clk(clk), .rst_n(rst_n[2]), .address(address[2]), .byteenable(be[2]),
        .read(rd[2]), .write(wr[2]), .writedata(wd[2]), .waitrequest(waitreq[2]),
        .readdata(rdata[2]), .readdatavalid(rvalid[2]), .range_error(rerr[2]),
        .proto_error(perr[2]), .rd_count(rdc[2]), .wr_count(wrc[2]));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int          m_pend [3];   // -1: no request in progress, else stall cycles still owed
    logic        m_hrd  [3];
    logic        m_hwr  [3];
    logic [31:0] m_haddr[3];
    logic [3:0]  m_hbe  [3];
    logic [15:0] m_lfsr [3];
    logic [31:0] m_rdata[3];
    logic        m_rv   [3];
    logic        m_rerr [3];
    logic        m_perr [3];
    logic [31:0] m_rdc  [3];
    logic [31:0] m_wrc  [3];
    logic [31:0] m_mem  [int];

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    function automatic int draw(input int k, input logic [15:0] l);
        if (k == 0) return 0;
        if (k == 1) return 3;
        return int'(l[3:0]) % 5;
    endfunction

    function automatic int mkey(input int k, input logic [31:0] a);
        logic [31:0] idx;
        idx = ((a - BASE) >> 2) & 32'h0000_0FFF;
        return k * 65536 + int'(idx);
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] b);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) if (b[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    always @(negedge clk) begin
        bit req, acc, chg, ew;
        int n, key;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n[k]) begin
                m_pend[k] = -1; m_lfsr[k] = 16'hACE1; m_rdata[k] = 32'h0; m_rv[k] = 1'b0;
                m_rerr[k] = 1'b0; m_perr[k] = 1'b0; m_rdc[k] = 32'h0; m_wrc[k] = 32'h0;
                m_hrd[k] = 1'b0; m_hwr[k] = 1'b0; m_haddr[k] = 32'h0; m_hbe[k] = 4'h0;
            end
            chk($sformatf("i%0d_readdata", k), rdata[k], m_rdata[k]);
            chk($sformatf("i%0d_readdatavalid", k), 32'(rvalid[k]), 32'(m_rv[k]));
            chk($sformatf("i%0d_range_error", k), 32'(rerr[k]), 32'(m_rerr[k]));
            chk($sformatf("i%0d_proto_error", k), 32'(perr[k]), 32'(m_perr[k]));
            chk($sformatf("i%0d_rd_count", k), rdc[k], m_rdc[k]);
            chk($sformatf("i%0d_wr_count", k), wrc[k], m_wrc[k]);
            req = (rd[k] || wr[k]);
            acc = 1'b0;
            ew  = 1'b0;
            if (rst_n[k]) begin
                if (m_pend[k] < 0) begin
                    if (req) begin
                        n = draw(k, m_lfsr[k]);
                        m_lfsr[k] = lfsr_next(m_lfsr[k]);
                        if (n == 0) acc = 1'b1;
                        else begin
                            ew = 1'b1; m_pend[k] = n - 1;
                            m_hrd[k] = rd[k]; m_hwr[k] = wr[k]; m_haddr[k] = address[k]; m_hbe[k] = be[k];
                        end
                    end
                end else begin
                    chg = !req || rd[k] != m_hrd[k] || wr[k] != m_hwr[k] ||
                          address[k][31:2] != m_haddr[k][31:2] || be[k] != m_hbe[k];
                    if (chg) begin
                        ew = req; m_perr[k] = 1'b1; m_pend[k] = -1;
                    end else if (m_pend[k] == 0) begin
                        acc = 1'b1; m_pend[k] = -1;
                    end else begin
                        ew = 1'b1; m_pend[k] = m_pend[k] - 1;
                    end
                end
            end
            chk($sformatf("i%0d_waitrequest", k), 32'(waitreq[k]), 32'(ew));
            m_rv[k] = 1'b0;
            if (acc) begin
                if (!(address[k] >= BASE && address[k] < BASE + 32'd16384)) m_rerr[k] = 1'b1;
                key = mkey(k, address[k]);
                if (rd[k] && wr[k]) m_perr[k] = 1'b1;
                else if (rd[k]) begin
                    m_rdata[k] = (m_mem.exists(key) ? m_mem[key] : 32'h0) & lanes(be[k]);
                    m_rv[k] = 1'b1;
                    if (m_rdc[k] != 32'hFFFF_FFFF) m_rdc[k] = m_rdc[k] + 1;
                end else begin
                    m_mem[key] = ((m_mem.exists(key) ? m_mem[key] : 32'h0) & ~lanes(be[k])) |
                                 (wd[k] & lanes(be[k]));
                    if (m_wrc[k] != 32'hFFFF_FFFF) m_wrc[k] = m_wrc[k] + 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic xfer(input int k, input bit r, input bit w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        output int stall, output logic [31:0] rdat, output logic rv);
        bit done;
        @(posedge clk); #1;
        rd[k] = r; wr[k] = w; address[k] = a; be[k] = b; wd[k] = d;
        stall = 0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!waitreq[k]) done = 1'b1;
            else stall++;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL i%0d_accept_timeout actual=stalled required=accepted", k);
        end
        @(posedge clk); #1;
        rd[k] = 1'b0; wr[k] = 1'b0;
        @(negedge clk);
        rdat = rdata[k];
        rv   = rvalid[k];
    endtask

    task automatic pulse_reset(input int k);
        @(posedge clk); #1 rst_n[k] = 1'b0;
        @(posedge clk); #1 rst_n[k] = 1'b1;
    endtask

    int          st;
    logic [31:0] rdv;
    logic        rvv;
    int          seqs [2][100];

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0;
            address[k] = BASE; be[k] = 4'h0; wd[k] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_waitrequest", 32'(waitreq[1]), 0);
        chk("reset_rd_count", rdc[1], 0);
        chk("reset_readdatavalid", 32'(rvalid[2]), 0);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

        // No-wait instance: write then read back.
        xfer(0, 0, 1, 32'hBFC00004, 4'hF, 32'hDEADBEEF, st, rdv, rvv);
        chk("m0_write_stall", 32'(st), 0);
        xfer(0, 1, 0, 32'hBFC00004, 4'hF, 32'h0, st, rdv, rvv);
        chk("m0_read_stall", 32'(st), 0);
        chk("m0_readdata", rdv, 32'hDEADBEEF);
        chk("m0_rvalid", 32'(rvv), 1);
        @(negedge clk);
        chk("m0_rvalid_single_pulse", 32'(rvalid[0]), 0);

        // Fixed three waits.
        xfer(1, 0, 1, 32'hBFC00010, 4'hF, 32'hCAFEF00D, st, rdv, rvv);
        chk("m1_write_stall", 32'(st), 3);
        xfer(1, 1, 0, 32'hBFC00010, 4'hF, 32'h0, st, rdv, rvv);
        chk("m1_read_stall", 32'(st), 3);
        chk("m1_readdata", rdv, 32'hCAFEF00D);
        chk("m1_rvalid_cycle5", 32'(rvv), 1);
        chk("m1_rd_count", rdc[1], 1);

        // Byte lanes.
        xfer(1, 0, 1, 32'hBFC00020, 4'hF, 32'h11223344, st, rdv, rvv);
        xfer(1, 0, 1, 32'hBFC00020, 4'b0100, 32'h00AA0000, st, rdv, rvv);
        xfer(1, 1, 0, 32'hBFC00020, 4'b0011, 32'h0, st, rdv, rvv);
        chk("lanes_partial_read", rdv, 32'h00003344);
        xfer(1, 1, 0, 32'hBFC00020, 4'hF, 32'h0, st, rdv, rvv);
        chk("lanes_full_read", rdv, 32'h11AA3344);

        // Master drops a read while stalled.
        @(posedge clk); #1;
        rd[1] = 1'b1; address[1] = 32'hBFC00020; be[1] = 4'hF;
        @(negedge clk);
        chk("drop_stalled", 32'(waitreq[1]), 1);
        @(posedge clk); #1 rd[1] = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        chk("drop_proto_error", 32'(perr[1]), 1);
        chk("drop_no_read", rdc[1], 3);

        // Memory survives reset; flags clear.
        pulse_reset(1);
        chk("reset_clears_proto", 32'(perr[1]), 0);
        xfer(1, 1, 0, 32'hBFC00020, 4'hF, 32'h0, st, rdv, rvv);
        chk("mem_kept_over_reset", rdv, 32'h11AA3344);

        // Read and write together.
        xfer(1, 1, 1, 32'hBFC00020, 4'hF, 32'hFFFFFFFF, st, rdv, rvv);
        chk("both_stall", 32'(st), 3);
        chk("both_proto_error", 32'(perr[1]), 1);
        xfer(1, 1, 0, 32'hBFC00020, 4'hF, 32'h0, st, rdv, rvv);
        chk("both_no_change", rdv, 32'h11AA3344);

        // Out of range, wraps onto word 0.
        xfer(1, 0, 1, 32'h00000000, 4'hF, 32'h12345678, st, rdv, rvv);
        chk("range_error_set", 32'(rerr[1]), 1);
        xfer(1, 1, 0, 32'hBFC00000, 4'hF, 32'h0, st, rdv, rvv);
        chk("range_wrap_data", rdv, 32'h12345678);
        chk("range_error_sticky", 32'(rerr[1]), 1);

        // Reset during a write stall.
        xfer(1, 0, 1, 32'hBFC00040, 4'hF, 32'h55AA55AA, st, rdv, rvv);
        @(posedge clk); #1;
        wr[1] = 1'b1; address[1] = 32'hBFC00040; be[1] = 4'hF; wd[1] = 32'hFFFFFFFF;
        @(negedge clk);
        chk("rst_stall_wait", 32'(waitreq[1]), 1);
        @(posedge clk); #1 rst_n[1] = 1'b0;
        #1;
        chk("rst_waitrequest", 32'(waitreq[1]), 0);
        chk("rst_wr_count", wrc[1], 0);
        chk("rst_rd_count", rdc[1], 0);
        chk("rst_range_error", 32'(rerr[1]), 0);
        wr[1] = 1'b0;
        @(posedge clk); #1 rst_n[1] = 1'b1;
        xfer(1, 1, 0, 32'hBFC00040, 4'hF, 32'h0, st, rdv, rvv);
        chk("rst_write_discarded", rdv, 32'h55AA55AA);

        // LFSR waits: two identical runs from reset.
        for (int r = 0; r < 2; r++) begin
            pulse_reset(2);
            xfer(2, 0, 1, 32'hBFC00100, 4'hF, 32'hA5A50F0F, st, rdv, rvv);
            chk("lfsr_first_draw", 32'(st), 1);
            for (int i = 0; i < 100; i++) begin
                xfer(2, 1, 0, 32'hBFC00100, 4'hF, 32'h0, st, rdv, rvv);
                seqs[r][i] = st;
                chk("lfsr_stall_bound", 32'(st <= 4), 1);
                chk("lfsr_readdata", rdv, 32'hA5A50F0F);
            end
        end
        chk("lfsr_seq0", 32'(seqs[0][0]), 0);
        chk("lfsr_seq1", 32'(seqs[0][1]), 3);
        chk("lfsr_seq2", 32'(seqs[0][2]), 2);
        for (int i = 0; i < 100; i++) begin
            chk($sformatf("lfsr_repeat_%0d", i), 32'(seqs[1][i]), 32'(seqs[0][i]));
        end
        chk("lfsr_rd_count", rdc[2], 100);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
